// File: rtl/arith_dec_if.sv
// Request/response bundle for arith_dec: encoded words and keys in, recovered operands out.
// The slave side is the decoder; the master side is whoever issues requests and consumes results.
interface arith_dec_if;
  logic        in_valid;
  logic        in_ready;
  logic [16:0] c1;
  logic [16:0] c2;
  logic [33:0] c3;
  logic [15:0] in1;
  logic [15:0] in5;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] rec2;
  logic [15:0] rec3;
  logic [15:0] rec4;
  logic [1:0]  err_code;

  modport slave (
    input  in_valid, c1, c2, c3, in1, in5, out_ready,
    output in_ready, out_valid, rec2, rec3, rec4, err_code
  );

  modport master (
    output in_valid, c1, c2, c3, in1, in5, out_ready,
    input  in_ready, out_valid, rec2, rec3, rec4, err_code
  );
endinterface

// File: rtl/arith_dec.sv
// Recovers in2/in3/in4 from encoded sum/difference/product words with a fixed 35-cycle
// latency, using a bit-serial restoring divider for the product term.
//   state | meaning
//   IDLE  | in_ready=1, waiting for a request
//   DIV   | one quotient bit per cycle, 34 cycles
//   FIX   | range/exactness check, result registered
//   DONE  | out_valid=1, results held until out_ready
module arith_dec (
  input  logic        clk,
  input  logic        rst,
  arith_dec_if.slave  bus
);

  typedef enum logic [1:0] {S_IDLE, S_DIV, S_FIX, S_DONE} state_t;

  state_t      r_state;
  state_t      w_next;
  logic [5:0]  r_cnt;
  logic [33:0] r_q;
  logic [16:0] r_rem;
  logic [15:0] r_in1;
  logic        r_neg;
  logic [15:0] r_rec2;
  logic [15:0] r_rec3;
  logic [15:0] r_rec4;
  logic [1:0]  r_err;

  logic [34:0] w_d;
  logic [33:0] w_absd;
  logic [16:0] w_sh;
  logic        w_ge;
  logic [16:0] w_sub;
  logic [18:0] w_t;
  logic [1:0]  w_err;

  assign w_d    = {1'b0, bus.c3} - {19'd0, bus.in5};
  // |D| < 2^34, so negating within 34 bits is exact
  assign w_absd = w_d[34] ? (34'd0 - w_d[33:0]) : w_d[33:0];

  assign w_sh  = {r_rem[15:0], r_q[33]};
  assign w_ge  = (w_sh >= {1'b0, r_in1});
  assign w_sub = w_ge ? (w_sh - {1'b0, r_in1}) : w_sh;
  assign w_t   = r_q[18:0] - {3'd0, r_rec2} - {3'd0, r_rec3};

  always_comb begin
    w_err = 2'd0;
    if (r_in1 == 16'd0)
      w_err = 2'd1;
    else if (r_neg)
      w_err = 2'd2;
    else if ((r_rem != 17'd0) || (w_t[18:16] != 3'd0))
      w_err = 2'd3;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (bus.in_valid)     w_next = S_DIV;
      S_DIV:   if (r_cnt == 6'd0)    w_next = S_FIX;
      S_FIX:                         w_next = S_DONE;
      S_DONE:  if (bus.out_ready)    w_next = S_IDLE;
      default:                       w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt  <= 6'd0;
      r_q    <= 34'd0;
      r_rem  <= 17'd0;
      r_in1  <= 16'd0;
      r_neg  <= 1'b0;
      r_rec2 <= 16'd0;
      r_rec3 <= 16'd0;
      r_rec4 <= 16'd0;
      r_err  <= 2'd0;
    end else begin
      case (r_state)
        S_IDLE: if (bus.in_valid) begin
          r_cnt  <= 6'd33;
          r_q    <= w_absd;
          r_rem  <= 17'd0;
          r_in1  <= bus.in1;
          r_neg  <= w_d[34];
          r_rec2 <= bus.c1[15:0] - bus.in1;
          r_rec3 <= bus.c2[15:0] + bus.c1[15:0];
          r_rec4 <= 16'd0;
          r_err  <= 2'd0;
        end
        S_DIV: begin
          r_q   <= {r_q[32:0], w_ge};
          r_rem <= w_sub;
          if (r_cnt != 6'd0) r_cnt <= r_cnt - 6'd1;
        end
        S_FIX: begin
          r_err  <= w_err;
          r_rec4 <= (w_err == 2'd0) ? w_t[15:0] : 16'd0;
        end
        default: ;
      endcase
    end
  end

  assign bus.in_ready  = (r_state == S_IDLE);
  assign bus.out_valid = (r_state == S_DONE);
  assign bus.rec2      = r_rec2;
  assign bus.rec3      = r_rec3;
  assign bus.rec4      = r_rec4;
  assign bus.err_code  = r_err;

endmodule

// File: tb/tb_arith_dec.sv
// Directed bench for arith_dec: decode table, stall, reset abort and back-to-back handshakes.
module tb_arith_dec;
  logic clk = 1'b0;
  logic rst;
  int   n_chk = 0;
  int   n_fail = 0;

  arith_dec_if bus();
  arith_dec dut (.clk(clk), .rst(rst), .bus(bus));

  always #5 clk = ~clk;

  typedef struct {
    logic [16:0] c1;
    logic [16:0] c2;
    logic [33:0] c3;
    logic [15:0] in1;
    logic [15:0] in5;
    logic [15:0] r2;
    logic [15:0] r3;
    logic [15:0] r4;
    logic [1:0]  err;
  } vec_t;

  vec_t vecs[10];
  logic [50:0] got, exp;

  task automatic set_in(input vec_t v);
    bus.c1 = v.c1; bus.c2 = v.c2; bus.c3 = v.c3; bus.in1 = v.in1; bus.in5 = v.in5;
  endtask

  task automatic start_req(input vec_t v);
    set_in(v);
    bus.in_valid = 1'b1;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
  endtask

  task automatic wait_valid(output int lat);
    lat = 0;
    while (bus.out_valid !== 1'b1 && lat < 80) begin
      @(posedge clk); #1;
      lat++;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; bus.in_valid = 1'b0; bus.out_ready = 1'b0;
    set_in(vecs[0]);
    repeat (3) @(posedge clk);
    #1;
    got = {bus.out_valid, bus.rec2, bus.rec3, bus.rec4, bus.err_code};
    n_chk++;
    if (got !== 51'd0) begin n_fail++; $display("FAIL reset_outputs got=%h exp=0", got); end
    rst = 1'b0;
    @(posedge clk); #1;
    n_chk++;
    if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0) begin
      n_fail++; $display("FAIL reset_release in_ready=%b out_valid=%b exp 1/0", bus.in_ready, bus.out_valid);
    end
  endtask

  task automatic test_decode();
    int lat;
    for (int i = 0; i < 10; i++) begin
      start_req(vecs[i]);
      // data and in_valid churn while busy must not disturb the result
      bus.c1 = 17'h1ffff; bus.c2 = 17'h0; bus.c3 = 34'h123; bus.in1 = 16'd7; bus.in5 = 16'd9;
      bus.in_valid = 1'b1;
      wait_valid(lat);
      bus.in_valid = 1'b0;
      n_chk++;
      if (lat != 35) begin n_fail++; $display("FAIL decode_latency vec=%0d got=%0d exp=35", i, lat); end
      got = {bus.out_valid, bus.rec2, bus.rec3, bus.rec4, bus.err_code};
      exp = {1'b1, vecs[i].r2, vecs[i].r3, vecs[i].r4, vecs[i].err};
      n_chk++;
      if (got !== exp) begin n_fail++; $display("FAIL decode_result vec=%0d got=%h exp=%h", i, got, exp); end
      bus.out_ready = 1'b1;
      @(posedge clk); #1;
      bus.out_ready = 1'b0;
      n_chk++;
      if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1) begin
        n_fail++; $display("FAIL decode_handshake vec=%0d out_valid=%b in_ready=%b exp 0/1", i, bus.out_valid, bus.in_ready);
      end
    end
  endtask

  task automatic test_stall();
    int lat;
    start_req(vecs[0]);
    wait_valid(lat);
    exp = {1'b1, vecs[0].r2, vecs[0].r3, vecs[0].r4, vecs[0].err};
    bus.in_valid = 1'b1;
    for (int k = 0; k < 10; k++) begin
      got = {bus.out_valid, bus.rec2, bus.rec3, bus.rec4, bus.err_code};
      n_chk++;
      if (got !== exp || bus.in_ready !== 1'b0) begin
        n_fail++; $display("FAIL stall_hold cyc=%0d got=%h exp=%h in_ready=%b", k, got, exp, bus.in_ready);
      end
      @(posedge clk); #1;
    end
    bus.in_valid = 1'b0;
    bus.out_ready = 1'b1;
    @(posedge clk); #1;
    bus.out_ready = 1'b0;
    n_chk++;
    if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1) begin
      n_fail++; $display("FAIL stall_release out_valid=%b in_ready=%b exp 0/1", bus.out_valid, bus.in_ready);
    end
  endtask

  task automatic test_reset_abort();
    int lat;
    int seen;
    start_req(vecs[0]);
    repeat (17) begin @(posedge clk); #1; end
    rst = 1'b1; #1;
    got = {bus.out_valid, bus.rec2, bus.rec3, bus.rec4, bus.err_code};
    n_chk++;
    if (got !== 51'd0) begin n_fail++; $display("FAIL abort_div_outputs got=%h exp=0", got); end
    @(posedge clk); #1;
    rst = 1'b0;
    seen = 0;
    for (int k = 0; k < 50; k++) begin
      @(posedge clk); #1;
      if (bus.out_valid === 1'b1) seen++;
    end
    n_chk++;
    if (seen != 0) begin n_fail++; $display("FAIL abort_div_no_valid got=%0d pulses exp=0", seen); end
    start_req(vecs[0]);
    wait_valid(lat);
    got = {bus.out_valid, bus.rec2, bus.rec3, bus.rec4, bus.err_code};
    exp = {1'b1, 16'd5, 16'd7, 16'd11, 2'd0};
    n_chk++;
    if (got !== exp || lat != 35) begin n_fail++; $display("FAIL abort_recover got=%h lat=%0d exp=%h lat=35", got, lat, exp); end
    // abort while results are being held
    rst = 1'b1; #1;
    n_chk++;
    if (bus.out_valid !== 1'b0 || bus.rec4 !== 16'd0) begin
      n_fail++; $display("FAIL abort_done out_valid=%b rec4=%0d exp 0/0", bus.out_valid, bus.rec4);
    end
    @(posedge clk); #1;
    rst = 1'b0;
    seen = 0;
    for (int k = 0; k < 40; k++) begin
      @(posedge clk); #1;
      if (bus.out_valid === 1'b1) seen++;
    end
    n_chk++;
    if (seen != 0) begin n_fail++; $display("FAIL abort_done_no_valid got=%0d pulses exp=0", seen); end
  endtask

  task automatic test_back_to_back();
    int lat;
    set_in(vecs[0]);
    bus.in_valid = 1'b1;
    @(posedge clk); #1;
    set_in(vecs[8]);
    wait_valid(lat);
    got = {bus.out_valid, bus.rec2, bus.rec3, bus.rec4, bus.err_code};
    exp = {1'b1, vecs[0].r2, vecs[0].r3, vecs[0].r4, vecs[0].err};
    n_chk++;
    if (got !== exp || lat != 35) begin n_fail++; $display("FAIL b2b_first got=%h lat=%0d exp=%h lat=35", got, lat, exp); end
    bus.out_ready = 1'b1;
    @(posedge clk); #1;
    bus.out_ready = 1'b0;
    n_chk++;
    if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1) begin
      n_fail++; $display("FAIL b2b_gap out_valid=%b in_ready=%b exp 0/1", bus.out_valid, bus.in_ready);
    end
    wait_valid(lat);
    bus.in_valid = 1'b0;
    got = {bus.out_valid, bus.rec2, bus.rec3, bus.rec4, bus.err_code};
    exp = {1'b1, vecs[8].r2, vecs[8].r3, vecs[8].r4, vecs[8].err};
    n_chk++;
    if (got !== exp || lat != 36) begin n_fail++; $display("FAIL b2b_second got=%h lat=%0d exp=%h lat=36", got, lat, exp); end
    bus.out_ready = 1'b1;
    @(posedge clk); #1;
    bus.out_ready = 1'b0;
  endtask

  initial begin
    //          c1      c2      c3                in1     in5     rec2    rec3    rec4    err
    vecs[0] = '{17'd8,      17'd131071, 34'd71,          16'd3,     16'd2,     16'd5,     16'd7,     16'd11,    2'd0};
    vecs[1] = '{17'd5,      17'd2,      34'd100,         16'd0,     16'd0,     16'd5,     16'd7,     16'd0,     2'd1};
    vecs[2] = '{17'd8,      17'd131071, 34'd1,           16'd3,     16'd2,     16'd5,     16'd7,     16'd0,     2'd2};
    vecs[3] = '{17'd8,      17'd131071, 34'd72,          16'd3,     16'd2,     16'd5,     16'd7,     16'd0,     2'd3};
    vecs[4] = '{17'd8,      17'd131071, 34'd32,          16'd3,     16'd2,     16'd5,     16'd7,     16'd0,     2'd3};
    vecs[5] = '{17'd1,      17'd131071, 34'd65535,       16'd1,     16'd0,     16'd0,     16'd0,     16'd65535, 2'd0};
    vecs[6] = '{17'd1,      17'd131071, 34'd65536,       16'd1,     16'd0,     16'd0,     16'd0,     16'd0,     2'd3};
    vecs[7] = '{17'd5,      17'd2,      34'd1,           16'd0,     16'd2,     16'd5,     16'd7,     16'd0,     2'd1};
    vecs[8] = '{17'd1000,   17'd130122, 34'd324535,      16'd700,   16'd65535, 16'd300,   16'd50,    16'd20,    2'd0};
    vecs[9] = '{17'd131070, 17'd65537,  34'd12884574210, 16'd65535, 16'd65535, 16'd65535, 16'd65535, 16'd65535, 2'd0};

    test_reset();
    test_decode();
    test_stall();
    test_reset_abort();
    test_back_to_back();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/arith_dec.md
ARITH_DEC -- requirements
Module: arith_dec

Interface
REQ-001 SHALL have port clk, input, 1 bit: single clock; all state updates on rising edge.
REQ-002 SHALL have port rst, input, 1 bit: asynchronous, active-high reset.
REQ-003 SHALL have port in_valid, input, 1 bit: request valid.
REQ-004 SHALL have port in_ready, output, 1 bit: block can accept a request.
REQ-005 SHALL have port c1, input, 17 bits: encoded sum word, c1 = in1+in2.
REQ-006 SHALL have port c2, input, 17 bits: encoded difference word, c2 = (in3-in2-in1) mod 2^17.
REQ-007 SHALL have port c3, input, 34 bits: encoded product word, c3 = in5 + in1*(in2+in3+in4).
REQ-008 SHALL have port in1, input, 16 bits: known key operand, unsigned.
REQ-009 SHALL have port in5, input, 16 bits: known offset operand, unsigned.
REQ-010 SHALL have port out_valid, output, 1 bit: result valid.
REQ-011 SHALL have port out_ready, input, 1 bit: consumer accepts result.
REQ-012 SHALL have port rec2, output, 16 bits: recovered in2.
REQ-013 SHALL have port rec3, output, 16 bits: recovered in3.
REQ-014 SHALL have port rec4, output, 16 bits: recovered in4.
REQ-015 SHALL have port err_code, output, 2 bits: 0 ok, 1 in1 zero, 2 c3<in5, 3 inexact/out of range.

Function
REQ-016 SHALL implement FSM states IDLE, DIV, FIX, DONE; in_ready=1 only in IDLE.
REQ-017 SHALL, on edge with in_valid&&in_ready, capture c1,c2,c3,in1,in5, load bit counter=33, enter DIV.
REQ-018 SHALL compute rec2=(c1-in1) mod 2^16 and rec3=(c2+c1) mod 2^16, valid regardless of err_code.
REQ-019 SHALL form D=c3-in5 in 35-bit signed arithmetic; D<0 selects err_code 2.
REQ-020 SHALL divide |D| by in1 with restoring division, one quotient bit per DIV cycle, 34 DIV cycles, quotient Q and remainder R.
REQ-021 SHALL in FIX compute T=Q-rec2-rec3 in 19-bit signed arithmetic; err_code 3 if R!=0 or T<0 or T>65535.
REQ-022 SHALL apply error priority: in1==0 (code 1) over D<0 (code 2) over code 3; divider still runs full length.
REQ-023 SHALL drive rec4=T[15:0] when err_code=0, else rec4=0.
REQ-024 SHALL have fixed latency: out_valid rises 35 cycles after the acceptance edge, independent of data.
REQ-025 SHALL, in DONE, hold out_valid=1 and all result outputs stable until out_ready=1.
REQ-026 SHALL on edge with out_valid&&out_ready return to IDLE, out_valid=0; no new request accepted in that same edge.
REQ-027 SHALL ignore in_valid and input data changes while not in IDLE.

Reset
REQ-028 SHALL on rst=1, immediately and asynchronously, enter IDLE, clear counter and data registers, drive out_valid=0, rec2=rec3=rec4=0, err_code=0.
REQ-029 SHALL, on rst asserted mid-DIV or in DONE, discard the in-flight request; no out_valid pulse follows release.
REQ-030 SHALL drive in_ready=1 on the first cycle after rst deassertion.

Verification
REQ-031 SHALL pass: c1=8, c2=131071, c3=71, in1=3, in5=2 -> after 35 cycles rec2=5, rec3=7, rec4=11, err_code=0.
REQ-032 SHALL pass: in1=0, c1=5, c2=2, c3=100, in5=0 -> rec2=5, rec3=7, rec4=0, err_code=1, latency 35.
REQ-033 SHALL pass: c1=8, c2=131071, c3=1, in1=3, in5=2 -> err_code=2, rec4=0; with c3=72 instead -> err_code=3 (R=1); with c3=32 -> err_code=3 (T=-2).
REQ-034 SHALL pass: out_ready held 0 for 10 cycles after out_valid -> outputs stable, in_ready=0; out_ready=1 -> IDLE next edge, in_ready=1.
REQ-035 SHALL pass: rst pulsed at cycle 17 of DIV -> outputs zero immediately, no out_valid; new request with REQ-031 data then completes correctly.
REQ-036 SHALL pass: back-to-back requests with in_valid held high -> second accepted only after first handshake, each 35-cycle latency, results in order.
